qspi_flash_responder: RTL

QSPI_FLASH_RESPONDER -- requirements
Module: qspi_flash_responder

---
 rtl/qspi_pkg.sv | 26 ++
 rtl/qspi_flash_responder_if.sv | 25 ++
 rtl/qspi_sck_edge_det.sv | 19 +
 rtl/qspi_flash_responder.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/qspi_pkg.sv
// Shared types and constants for the quad-SPI flash read responder.
package qspi_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CMD,
    ST_ADDR,
    ST_MODE,
    ST_DUMMY,
    ST_DATA,
    ST_IGNORE
  } state_e;

  localparam logic [7:0] QSPI_CMD_QIOR      = 8'hEB;
  localparam logic [1:0] QSPI_MODE_CONT     = 2'b10;
  localparam int         QSPI_DUMMY_DEFAULT = 4;

  localparam logic [3:0] CMD_BIT_LAST  = 4'd7;
  localparam logic [3:0] ADDR_NIB_LAST = 4'd5;

  // Mode byte bits [5:4] == 2'b10 lets the next transaction skip the opcode.
  function automatic logic mode_is_cont(input logic [7:0] mode);
    return mode[5:4] == QSPI_MODE_CONT;
  endfunction

endpackage

// File: rtl/qspi_flash_responder_if.sv
// Flash-side QSPI lines plus the backing-store read port of the responder.
interface qspi_flash_responder_if #(
  parameter int ADDR_W = 24
);
  logic              sck;
  logic              ce_n;
  logic [3:0]        io_in;
  logic [3:0]        io_out;
  logic              io_oe;
  logic              mem_rd;
  logic [ADDR_W-1:0] mem_addr;
  logic [7:0]        mem_rdata;

  // Store port has no ready: mem_rd is a one-clk strobe qualified by mem_addr,
  // and mem_rdata must hold the addressed byte exactly one clk after mem_rd.
  modport master (
    output sck, ce_n, io_in, mem_rdata,
    input  io_out, io_oe, mem_rd, mem_addr
  );

  modport slave (
    input  sck, ce_n, io_in, mem_rdata,
    output io_out, io_oe, mem_rd, mem_addr
  );
endinterface

// File: rtl/qspi_sck_edge_det.sv
// Detects sck rising/falling edges in the clk domain, gated by chip enable.
module qspi_sck_edge_det (
  input  logic clk,
  input  logic rst,
  input  logic sck,
  input  logic ce_n,
  output logic rise,
  output logic fall
);
  logic sck_d;

  always_ff @(posedge clk) begin
    if (rst) sck_d <= 1'b0;
    else     sck_d <= sck;
  end

  assign rise = sck  & ~sck_d & ~ce_n;
  assign fall = ~sck &  sck_d & ~ce_n;
endmodule

// File: rtl/qspi_flash_responder.sv
// Quad-IO fast-read (0xEB) flash responder with continuous-read mode,
// backed by an external byte store with one-clk read latency.
module qspi_flash_responder
  import qspi_pkg::*;
#(
  parameter int DUMMY_CYCLES = QSPI_DUMMY_DEFAULT,
  parameter int ADDR_W       = 24
) (
  input  logic                  clk,
  input  logic                  rst,
  qspi_flash_responder_if.slave bus,
  output state_e                dbg_state,
  output logic                  dbg_cont_mode
);
  localparam logic [3:0]        DUMMY_LAST = 4'(DUMMY_CYCLES - 1);
  localparam logic [ADDR_W-1:0] ADDR_ONE   = {{(ADDR_W-1){1'b0}}, 1'b1};

  logic rise, fall;

  state_e            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [7:0]        cmd_q, cmd_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [3:0]        mode_hi_q, mode_hi_d;
  logic              cont_q, cont_d;
  logic [3:0]        io_out_q, io_out_d;
  logic              io_oe_q, io_oe_d;
  logic              mem_rd_q, mem_rd_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic              hi_next_q, hi_next_d;
  logic [3:0]        lo_nib_q, lo_nib_d;
  logic [7:0]        data_buf_q;
  logic              rd_pend_q;

  logic [7:0]        cmd_next;
  logic [ADDR_W-1:0] addr_next;
  logic [ADDR_W-1:0] addr_inc;

  qspi_sck_edge_det u_edge (
    .clk  (clk),
    .rst  (rst),
    .sck  (bus.sck),
    .ce_n (bus.ce_n),
    .rise (rise),
    .fall (fall)
  );

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    cmd_d      = cmd_q;
    addr_d     = addr_q;
    mode_hi_d  = mode_hi_q;
    cont_d     = cont_q;
    io_out_d   = io_out_q;
    io_oe_d    = io_oe_q;
    mem_rd_d   = 1'b0;
    mem_addr_d = mem_addr_q;
    hi_next_d  = hi_next_q;
    lo_nib_d   = lo_nib_q;
    cmd_next   = {cmd_q[6:0], bus.io_in[0]};
    addr_next  = {addr_q[ADDR_W-5:0], bus.io_in};
    addr_inc   = addr_q + ADDR_ONE;

    if (bus.ce_n) begin
      // Deselect discards any partial phase; cont_mode survives.
      state_d  = ST_IDLE;
      cnt_d    = 4'd0;
      io_out_d = 4'd0;
      io_oe_d  = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          state_d   = cont_q ? ST_ADDR : ST_CMD;
          cnt_d     = 4'd0;
          cmd_d     = 8'd0;
          addr_d    = '0;
          hi_next_d = 1'b1;
        end
        ST_CMD: if (rise) begin
          cmd_d = cmd_next;
          cnt_d = cnt_q + 4'd1;
          if (cnt_q == CMD_BIT_LAST) begin
            cnt_d   = 4'd0;
            state_d = (cmd_next == QSPI_CMD_QIOR) ? ST_ADDR : ST_IGNORE;
          end
        end
        ST_ADDR: if (rise) begin
          addr_d = addr_next;
          cnt_d  = cnt_q + 4'd1;
          if (cnt_q == ADDR_NIB_LAST) begin
            cnt_d      = 4'd0;
            state_d    = ST_MODE;
            mem_rd_d   = 1'b1;
            mem_addr_d = addr_next;
          end
        end
        ST_MODE: if (rise) begin
          cnt_d = cnt_q + 4'd1;
          if (cnt_q == 4'd0) begin
            mode_hi_d = bus.io_in;
          end else begin
            cont_d  = mode_is_cont({mode_hi_q, bus.io_in});
            cnt_d   = 4'd0;
            state_d = ST_DUMMY;
          end
        end
        ST_DUMMY: if (rise) begin
          cnt_d = cnt_q + 4'd1;
          if (cnt_q == DUMMY_LAST) begin
            cnt_d     = 4'd0;
            state_d   = ST_DATA;
            hi_next_d = 1'b1;
          end
        end
        ST_DATA: if (fall) begin
          io_oe_d = 1'b1;
          if (hi_next_q) begin
            // Park the low nibble so the prefetch may overwrite the buffer.
            io_out_d   = data_buf_q[7:4];
            lo_nib_d   = data_buf_q[3:0];
            addr_d     = addr_inc;
            mem_rd_d   = 1'b1;
            mem_addr_d = addr_inc;
            hi_next_d  = 1'b0;
          end else begin
            io_out_d  = lo_nib_q;
            hi_next_d = 1'b1;
          end
        end
        ST_IGNORE: ;
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      cnt_q      <= 4'd0;
      cmd_q      <= 8'd0;
      addr_q     <= '0;
      mode_hi_q  <= 4'd0;
      cont_q     <= 1'b0;
      io_out_q   <= 4'd0;
      io_oe_q    <= 1'b0;
      mem_rd_q   <= 1'b0;
      mem_addr_q <= '0;
      hi_next_q  <= 1'b1;
      lo_nib_q   <= 4'd0;
      data_buf_q <= 8'd0;
      rd_pend_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      cmd_q      <= cmd_d;
      addr_q     <= addr_d;
      mode_hi_q  <= mode_hi_d;
      cont_q     <= cont_d;
      io_out_q   <= io_out_d;
      io_oe_q    <= io_oe_d;
      mem_rd_q   <= mem_rd_d;
      mem_addr_q <= mem_addr_d;
      hi_next_q  <= hi_next_d;
      lo_nib_q   <= lo_nib_d;
      rd_pend_q  <= mem_rd_q;
      if (rd_pend_q) data_buf_q <= bus.mem_rdata;
    end
  end

  assign bus.io_out   = io_out_q;
  assign bus.io_oe    = io_oe_q;
  assign bus.mem_rd   = mem_rd_q;
  assign bus.mem_addr = mem_addr_q;
  assign dbg_state     = state_q;
  assign dbg_cont_mode = cont_q;
endmodule
